// File: rtl/bemf_pkg.sv
// Shared types and helpers for the BEMF pulse-train transmitter.
package bemf_pkg;

    localparam int BEMF_WIDTH = 32;
    localparam int BEMF_CNT_W = 16;
    localparam int MIN_W_MAX  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    // Callers widen their operands to MIN_W_MAX and narrow the result back.
    function automatic logic [MIN_W_MAX-1:0] min_w(input logic [MIN_W_MAX-1:0] a,
                                                   input logic [MIN_W_MAX-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/bemf_pulse_generator_if.sv
// Configuration channel of the pulse generator.
// Handshake: data is stable while cfg_valid=1; a word transfers on a clk edge
// where cfg_valid & cfg_ready, and cfg_ready never depends on cfg_valid.
interface bemf_pulse_generator_if #(
    parameter int WIDTH = bemf_pkg::BEMF_WIDTH,
    parameter int CNT_W = bemf_pkg::BEMF_CNT_W
);
    logic [WIDTH-1:0] cfg_high;
    logic [WIDTH-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_count;
    logic             cfg_valid;
    logic             cfg_ready;

    modport master (
        output cfg_high, cfg_period, cfg_count, cfg_valid,
        input  cfg_ready
    );

    modport slave (
        input  cfg_high, cfg_period, cfg_count, cfg_valid,
        output cfg_ready
    );
endinterface

// File: rtl/bemf_pulse_generator_cfg.sv
// One-entry valid/ready holding register for a pulse configuration.
module cfg_holding_reg #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_high,
    input  logic [WIDTH-1:0] in_period,
    input  logic [CNT_W-1:0] in_count,
    output logic             in_ready,
    input  logic             take,
    output logic             full,
    output logic [WIDTH-1:0] out_high,
    output logic [WIDTH-1:0] out_period,
    output logic [CNT_W-1:0] out_count
);

    logic fire;

    assign in_ready = ~full;
    assign fire     = in_valid & ~full;

    // take is only ever raised while full, so it can never collide with fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full       <= 1'b0;
            out_high   <= '0;
            out_period <= '0;
            out_count  <= '0;
        end else if (fire) begin
            full       <= 1'b1;
            out_high   <= in_high;
            out_period <= in_period;
            out_count  <= in_count;
        end else if (take) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/bemf_pulse_generator.sv
// Programmable pulse-train transmitter: exact high-time and period in clk
// cycles, optional finite bursts, new settings applied only at period edges.
module bemf_pulse_generator
    import bemf_pkg::*;
#(
    parameter int WIDTH = BEMF_WIDTH,
    parameter int CNT_W = BEMF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    bemf_pulse_generator_if.slave   cfg,
    output logic                    sig_out,
    output logic                    period_start,
    output logic                    burst_done,
    output logic                    busy,
    output state_t                  state_dbg
);

    state_t           state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] high_act, high_act_n;
    logic [WIDTH-1:0] period_act, period_act_n;
    logic [CNT_W-1:0] count_act, count_act_n;
    logic [CNT_W-1:0] pulses, pulses_n;

    logic             pend_full;
    logic [WIDTH-1:0] pend_high;
    logic [WIDTH-1:0] pend_period;
    logic [CNT_W-1:0] pend_count;
    logic [WIDTH-1:0] pend_high_eff;

    logic             pend_clear;
    logic             take_pend;
    logic             start_n;
    logic             last_cycle;
    logic             burst_last;
    logic             sig_q;
    logic             ps_q;

    cfg_holding_reg #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cfg (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (cfg.cfg_valid),
        .in_high    (cfg.cfg_high),
        .in_period  (cfg.cfg_period),
        .in_count   (cfg.cfg_count),
        .in_ready   (cfg.cfg_ready),
        .take       (pend_clear),
        .full       (pend_full),
        .out_high   (pend_high),
        .out_period (pend_period),
        .out_count  (pend_count)
    );

    assign pend_high_eff = WIDTH'(min_w(MIN_W_MAX'(pend_high), MIN_W_MAX'(pend_period)));
    assign last_cycle    = (state != IDLE) && (cnt == period_act - 1'b1);
    assign burst_last    = (count_act != '0) && (CNT_W'(pulses + 1'b1) == count_act);

    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        high_act_n   = high_act;
        period_act_n = period_act;
        count_act_n  = count_act;
        pulses_n     = pulses;
        pend_clear   = 1'b0;
        take_pend    = 1'b0;
        start_n      = 1'b0;
        burst_done   = 1'b0;

        case (state)
            IDLE: begin
                // A zero-period config is consumed without ever starting.
                if (pend_full) begin
                    if (pend_period == '0) begin
                        pend_clear = 1'b1;
                    end else if (enable) begin
                        pend_clear = 1'b1;
                        take_pend  = 1'b1;
                    end
                end
            end
            HIGH, LOW: begin
                if (!last_cycle) begin
                    cnt_n = cnt + 1'b1;
                    if (state == HIGH && cnt == high_act - 1'b1) begin
                        state_n = LOW;
                    end
                end else if (!enable) begin
                    state_n = IDLE;
                end else if (burst_last) begin
                    burst_done = 1'b1;
                    state_n    = IDLE;
                end else if (pend_full) begin
                    pend_clear = 1'b1;
                    if (pend_period == '0) begin
                        state_n = IDLE;
                    end else begin
                        take_pend = 1'b1;
                    end
                end else begin
                    cnt_n   = '0;
                    start_n = 1'b1;
                    state_n = (high_act != '0) ? HIGH : LOW;
                    if (count_act != '0) begin
                        pulses_n = pulses + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (take_pend) begin
            high_act_n   = pend_high_eff;
            period_act_n = pend_period;
            count_act_n  = pend_count;
            cnt_n        = '0;
            pulses_n     = '0;
            start_n      = 1'b1;
            state_n      = (pend_high_eff != '0) ? HIGH : LOW;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            high_act   <= '0;
            period_act <= '0;
            count_act  <= '0;
            pulses     <= '0;
            sig_q      <= 1'b0;
            ps_q       <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            high_act   <= high_act_n;
            period_act <= period_act_n;
            count_act  <= count_act_n;
            pulses     <= pulses_n;
            sig_q      <= (state_n == HIGH);
            ps_q       <= start_n;
        end
    end

    assign sig_out      = sig_q;
    assign period_start = ps_q;
    assign busy         = (state != IDLE);
    assign state_dbg    = state;

endmodule
